// File: rtl/col_vec_gen_if.sv
// rtl/col_vec_gen_if.sv - pixel-in / column-vector-out handshake bundle for col_vec_gen
interface col_vec_gen_if #(
   parameter int DATA_W   = 8,
   parameter int KERNEL_H = 7
);
   logic                             i_vld;
   logic                             i_eof;
   logic [DATA_W-1:0]                i_data;
   logic                             o_rdy;
   logic                             i_rdy;
   logic                             o_vld;
   logic                             o_eof;
   logic [KERNEL_H-1:0][DATA_W-1:0]  o_data;
   logic                             o_short_frame;

   modport master (
      output i_vld, i_eof, i_data, i_rdy,
      input  o_rdy, o_vld, o_eof, o_data, o_short_frame
   );

   modport slave (
      input  i_vld, i_eof, i_data, i_rdy,
      output o_rdy, o_vld, o_eof, o_data, o_short_frame
   );
endinterface

// File: rtl/col_vec_gen.sv
// rtl/col_vec_gen.sv - raster pixel stream to KERNEL_H-tall column vectors for col_pe
module col_vec_gen #(
   parameter int DATA_W   = 8,
   parameter int KERNEL_H = 7,
   parameter int IMG_W    = 64
) (
   input  logic           i_clk,
   input  logic           i_rst,
   col_vec_gen_if.slave   bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(KERNEL_H);
   localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_FULL       = RW'(KERNEL_H - 1);
   localparam logic [RW-1:0] ROW_PRIME_LAST = RW'(KERNEL_H - 2);

   typedef enum logic {PRIME, STREAM} state_t;

   state_t                           r_state;
   logic [CW-1:0]                    r_col_cnt;
   logic [RW-1:0]                    r_row_cnt;
   logic                             r_o_vld;
   logic                             r_o_eof;
   logic                             r_o_short_frame;
   logic [KERNEL_H-1:0][DATA_W-1:0]  r_o_data;
   logic [DATA_W-1:0]                r_line [KERNEL_H-1][IMG_W];

   logic                             w_accept;
   logic                             w_col_last;
   logic [RW-1:0]                    w_row_next;
   logic [KERNEL_H-1:0][DATA_W-1:0]  w_vec;

   assign bus.o_rdy         = !r_o_vld || bus.i_rdy;
   assign bus.o_vld         = r_o_vld;
   assign bus.o_eof         = r_o_eof;
   assign bus.o_data        = r_o_data;
   assign bus.o_short_frame = r_o_short_frame;

   assign w_accept   = bus.i_vld && bus.o_rdy;
   assign w_col_last = (r_col_cnt == COL_LAST);
   assign w_row_next = (r_row_cnt == ROW_FULL) ? r_row_cnt : r_row_cnt + 1'b1;

   // Column vector reads the pre-write line contents; newest row is the live pixel.
   always_comb begin
      w_vec = '0;
      for (int k = 0; k < KERNEL_H - 1; k++) begin
         w_vec[k] = r_line[k][r_col_cnt];
      end
      w_vec[KERNEL_H-1] = bus.i_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && w_accept) begin
         for (int k = 0; k < KERNEL_H - 2; k++) begin
            r_line[k][r_col_cnt] <= r_line[k+1][r_col_cnt];
         end
         r_line[KERNEL_H-2][r_col_cnt] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= PRIME;
         r_col_cnt       <= '0;
         r_row_cnt       <= '0;
         r_o_vld         <= 1'b0;
         r_o_eof         <= 1'b0;
         r_o_data        <= '0;
         r_o_short_frame <= 1'b0;
      end else begin
         r_o_short_frame <= 1'b0;
         if (r_o_vld && bus.i_rdy) begin
            r_o_vld <= 1'b0;
         end
         if (w_accept) begin
            if (bus.i_eof) begin
               r_col_cnt <= '0;
               r_row_cnt <= '0;
               r_state   <= PRIME;
            end else begin
               r_col_cnt <= w_col_last ? '0 : r_col_cnt + 1'b1;
               if (w_col_last) begin
                  r_row_cnt <= w_row_next;
               end
            end
            if (r_state == STREAM) begin
               r_o_data <= w_vec;
               r_o_vld  <= 1'b1;
               r_o_eof  <= bus.i_eof;
            end else if (bus.i_eof) begin
               r_o_short_frame <= 1'b1;
            end else if (w_col_last && r_row_cnt == ROW_PRIME_LAST) begin
               r_state <= STREAM;
            end
         end
      end
   end
endmodule

// File: tb/tb_col_vec_gen.sv
// tb/tb_col_vec_gen.sv - self-checking bench for col_vec_gen with a raster-window model
module tb_col_vec_gen;
   localparam int DW = 8;
   localparam int KH = 7;
   localparam int IW = 4;

   logic clk;
   logic rst;

   col_vec_gen_if #(.DATA_W(DW), .KERNEL_H(KH)) bus ();

   col_vec_gen #(.DATA_W(DW), .KERNEL_H(KH), .IMG_W(IW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int short_seen = 0;

   logic                m_vld;
   logic                m_eof;
   logic                m_short;
   logic [KH*DW-1:0]    m_data;
   logic [DW-1:0]       frame_q[$];

   logic [KH*DW-1:0]    got_d[$];
   logic                got_e[$];
   logic [KH*DW-1:0]    ref_d[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected column vector: the same column in the KH-1 rows above plus the current pixel.
   function automatic logic [KH*DW-1:0] window(input int idx);
      logic [KH*DW-1:0] v;
      v = '0;
      for (int k = 0; k < KH; k++) begin
         v[k*DW +: DW] = frame_q[idx - (KH-1-k)*IW];
      end
      return v;
   endfunction

   task automatic step(input logic vld, input logic eof, input logic [DW-1:0] d,
                       input logic rdy, output logic acc);
      logic exp_rdy;
      int   idx;
      @(negedge clk);
      bus.i_vld  = vld;
      bus.i_eof  = eof;
      bus.i_data = d;
      bus.i_rdy  = rdy;
      exp_rdy = !m_vld || rdy;
      acc = vld && exp_rdy;
      #1;
      chk("o_rdy", 64'(bus.o_rdy), 64'(exp_rdy));
      if (bus.o_vld && rdy) begin
         got_d.push_back(bus.o_data);
         got_e.push_back(bus.o_eof);
      end
      m_short = 1'b0;
      if (m_vld && rdy) m_vld = 1'b0;
      if (acc) begin
         frame_q.push_back(d);
         idx = frame_q.size() - 1;
         if (idx / IW >= KH - 1) begin
            m_data = window(idx);
            m_vld  = 1'b1;
            m_eof  = eof;
         end else if (eof) begin
            m_short = 1'b1;
         end
         if (eof) frame_q.delete();
      end
      @(posedge clk);
      #1;
      chk("o_vld", 64'(bus.o_vld), 64'(m_vld));
      if (m_vld) begin
         chk("o_data", 64'(bus.o_data), 64'(m_data));
         chk("o_eof", 64'(bus.o_eof), 64'(m_eof));
      end
      chk("o_short_frame", 64'(bus.o_short_frame), 64'(m_short));
      if (bus.o_short_frame) short_seen++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_vld = 1'b0;
      bus.i_eof = 1'b0;
      bus.i_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_vld = 1'b0; m_eof = 1'b0; m_short = 1'b0; m_data = '0;
      frame_q.delete();
      chk("rst_o_vld", 64'(bus.o_vld), 64'd0);
      chk("rst_o_eof", 64'(bus.o_eof), 64'd0);
      chk("rst_o_data", 64'(bus.o_data), 64'd0);
      chk("rst_o_short", 64'(bus.o_short_frame), 64'd0);
   endtask

   task automatic send_pixels(input int npix, input bit with_eof, input bit vld_rand,
                              input bit rdy_rand, input bit data_rand, input int stall_vec);
      int sent = 0;
      int cyc = 0;
      int stall = 0;
      logic acc, v, r, e;
      logic [DW-1:0] d;
      d = data_rand ? DW'($urandom) : 8'h00;
      while (sent < npix && cyc < 1000) begin
         v = vld_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         r = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (stall_vec >= 0 && got_d.size() == stall_vec && stall < 3 && m_vld) begin
            r = 1'b0;
            stall++;
         end
         e = with_eof && (sent == npix - 1);
         step(v, e, d, r, acc);
         cyc++;
         if (acc) begin
            sent++;
            d = data_rand ? DW'($urandom) : DW'((sent / IW) * 16 + (sent % IW));
         end
      end
      if (sent != npix) chk("send_budget", 64'(sent), 64'(npix));
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && m_vld; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, acc);
      end
      step(1'b0, 1'b0, '0, 1'b1, acc);
      chk("drained", 64'(bus.o_vld), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.i_vld = 1'b0; bus.i_eof = 1'b0; bus.i_data = '0; bus.i_rdy = 1'b0;
      m_vld = 1'b0; m_eof = 1'b0; m_short = 1'b0; m_data = '0;
      do_reset();

      // continuous 4x8 frame
      got_d.delete(); got_e.delete();
      send_pixels(IW*8, 1, 0, 0, 0, -1);
      drain();
      chk("f1_count", 64'(got_d.size()), 64'd8);
      if (got_d.size() == 8) begin
         chk("f1_first", 64'(got_d[0]), 64'h60504030201000);
         chk("f1_last", 64'(got_d[7]), 64'h73635343332313);
         chk("f1_last_eof", 64'(got_e[7]), 64'd1);
         chk("f1_first_eof", 64'(got_e[0]), 64'd0);
      end
      ref_d = got_d;

      // same frame with a 3-cycle stall at vector 3
      got_d.delete(); got_e.delete();
      send_pixels(IW*8, 1, 0, 0, 0, 3);
      drain();
      chk("bp_count", 64'(got_d.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_d.size(); i++) begin
         chk("bp_same_seq", 64'(got_d[i]), 64'(ref_d[i]));
      end

      // short frame then full frame
      got_d.delete(); got_e.delete();
      short_seen = 0;
      send_pixels(IW*3, 1, 0, 0, 0, -1);
      drain();
      chk("short_no_vec", 64'(got_d.size()), 64'd0);
      chk("short_pulses", 64'(short_seen), 64'd1);
      send_pixels(IW*8, 1, 0, 0, 0, -1);
      drain();
      chk("after_short_count", 64'(got_d.size()), 64'd8);
      if (got_d.size() == 8) chk("after_short_first", 64'(got_d[0]), 64'h60504030201000);

      // mid-row eof
      got_d.delete(); got_e.delete();
      send_pixels(IW*7 + 2, 1, 0, 0, 0, -1);
      drain();
      chk("midrow_count", 64'(got_d.size()), 64'd6);
      if (got_d.size() == 6) begin
         chk("midrow_last", 64'(got_d[5]), 64'h71615141312111);
         chk("midrow_last_eof", 64'(got_e[5]), 64'd1);
         chk("midrow_prev_eof", 64'(got_e[4]), 64'd0);
      end
      got_d.delete(); got_e.delete();
      send_pixels(IW*8, 1, 0, 0, 0, -1);
      drain();
      chk("midrow_next_count", 64'(got_d.size()), 64'd8);
      if (got_d.size() == 8) chk("midrow_next_first", 64'(got_d[0]), 64'h60504030201000);

      // three back-to-back frames with random bubbles and random data
      got_d.delete(); got_e.delete();
      for (int f = 0; f < 3; f++) send_pixels(IW*8, 1, 1, 1, 1, -1);
      drain();
      chk("bubble_count", 64'(got_d.size()), 64'd24);
      for (int i = 0; i < got_d.size(); i++) begin
         chk("bubble_eof_pos", 64'(got_e[i]), 64'(i % 8 == 7));
      end

      // reset during row 7
      send_pixels(IW*7 + 1, 0, 0, 0, 0, -1);
      do_reset();
      got_d.delete(); got_e.delete();
      send_pixels(IW*8, 1, 0, 0, 0, -1);
      drain();
      chk("post_rst_count", 64'(got_d.size()), 64'd8);
      if (got_d.size() == 8) chk("post_rst_first", 64'(got_d[0]), 64'h60504030201000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/col_vec_gen.md
Name: col_vec_gen

Overview:
- Raster-to-column front end that feeds `col_pe`.
- Accepts a row-major pixel stream and buffers the previous KERNEL_H-1 image rows in line memory.
- For every incoming pixel once the buffer is primed, emits the KERNEL_H-tall column vector ending at that pixel, using the same vld/rdy/eof handshake that `col_pe` consumes.
- Frame end is marked by i_eof and forwarded as o_eof on the matching vector.

Parameters:
- DATA_W, 8, pixel width in bits (unsigned).
- KERNEL_H, 7, column vector height; must be ≥ 2.
- IMG_W, 64, pixels per image row; must be ≥ 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_vld  in  1  input pixel valid.
- i_eof  in  1  input pixel is the last pixel of the frame.
- i_data  in  DATA_W  input pixel.
- o_rdy  out  1  block can accept a pixel this cycle.
- i_rdy  in  1  downstream (`col_pe`) ready.
- o_vld  out  1  o_data/o_eof hold a valid column vector.
- o_eof  out  1  vector is the last one of the frame.
- o_data  out  [KERNEL_H-1:0][DATA_W-1:0]  column vector; index 0 = oldest row (top), index KERNEL_H-1 = current pixel.
- o_short_frame  out  1  one-cycle pulse when an eof arrives before the buffer is primed.

Behaviour:
- Reset (synchronous): o_vld=0, o_eof=0, o_data=0, o_short_frame=0, col_cnt=0, row_cnt=0, state=PRIME. Line memory contents are not reset.
- Accept condition: o_rdy = !o_vld || i_rdy (combinational). A pixel is accepted when i_vld && o_rdy.
- Line memory: KERNEL_H-1 lines × IMG_W entries, written as a per-column shift. On accept at column c:
  - line[k][c] <= line[k+1][c] for k = 0..KERNEL_H-3;
  - line[KERNEL_H-2][c] <= i_data.
  - Reads of column c use the pre-write values.
- Vector formation: o_data[k] = line[k][col_cnt] for k < KERNEL_H-1; o_data[KERNEL_H-1] = i_data.
- Counters: on accept, col_cnt increments and wraps from IMG_W-1 to 0. On wrap, row_cnt increments, saturating at KERNEL_H-1.
- FSM states:
  - PRIME (row_cnt < KERNEL_H-1): accepted pixels update memory only; o_vld is cleared if i_rdy consumes the held vector. Moves to STREAM on accepting the pixel at col_cnt=IMG_W-1 while row_cnt=KERNEL_H-2.
  - STREAM: every accepted pixel loads o_data, sets o_vld=1 and sets o_eof=i_eof on the next edge, i.e. 1-cycle latency.
- Output hold: when o_vld && !i_rdy, o_data, o_eof and o_vld are held stable and no pixel is accepted.
- Output drain: when o_vld && i_rdy with no accept, o_vld goes to 0 on the next edge. When o_vld && i_rdy with an accept in STREAM, a back-to-back reload occurs, giving 1 vector per cycle sustained.
- EOF in STREAM: the vector carries o_eof=1. Counters reset to 0 and state goes to PRIME on the same edge, so the next frame re-primes. This applies even when the eof arrives mid-row (col_cnt ≠ IMG_W-1): the partial row is emitted normally, then counters reset.
- EOF in PRIME: no vector is produced, o_short_frame pulses high for 1 cycle, and counters reset to 0.
- i_eof without i_vld is ignored. i_data and i_eof are sampled only on accept.
- Reset asserted mid-frame: the in-flight vector is discarded (o_vld=0 next cycle) and the next pixel is treated as row 0, col 0 of a new frame.
- Stale line memory from a previous frame is never emitted, because a full re-prime always overwrites all KERNEL_H-1 lines for each column before STREAM.

Test Plan:
- Reset check: with IMG_W=4, KERNEL_H=7, drive a continuous 4×8 frame (pixel = row*16+col, eof on the last pixel) with i_rdy=1 → exactly 8 vectors. The first is {0x00,0x10,0x20,0x30,0x40,0x50,0x60} (index 0..6). The last is {0x13,0x23,...,0x73} with o_eof=1. No vld gap after the first vector.
- Backpressure: same frame, i_rdy low for 3 cycles at vector 3 → o_data/o_eof are stable and o_vld stays 1 during the stall, o_rdy=0, no pixel is lost, and the sequence is identical to the previous test.
- Short frame: 4×3 frame with eof on the last pixel → no o_vld ever, o_short_frame pulses once. A following full 4×8 frame produces the correct 8 vectors.
- Mid-row eof: 4×7 frame plus 2 pixels of row 7, eof on the 2nd → 6 vectors total: 4 from row 6, then 2 from row 7, the last one ({0x11,...,0x71}) with o_eof=1. The next frame re-primes correctly.
- Bubbles: random i_vld (50%) and random i_rdy (50%) over 3 back-to-back 4×8 frames, checked against a software raster-window model → all 24 vectors match in order, and o_eof appears on vectors 8, 16 and 24 only.
- Reset mid-frame: assert i_rst for 1 cycle during row 7 → o_vld=0 next cycle. A subsequent full frame's first vector is {0x00,...,0x60}.
